// File: rtl/demux_pkg.sv
// Shared constants for the 2-way stream demultiplexer: select encodings,
// default word width and the clog2 helper used to size counts and pointers.
package demux_pkg;

   localparam logic DEMUX_SEL_A = 1'b0;
   localparam logic DEMUX_SEL_B = 1'b1;

   localparam int DEMUX_DEFAULT_WIDTH = 5;

   // Ceiling log2; clog2(1) is 0, so callers needing at least one bit must clamp.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small DEPTH-entry buffer feeding one output of the demux. The head word is
// held in its own register so the output holds its last value once drained.
module demux_fifo
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_DEFAULT_WIDTH,
   parameter int DEPTH = 2,
   localparam int CW = clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_head;
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;

   logic             w_push;
   logic             w_pop;
   logic [PW-1:0]    w_wrPtrNext;
   logic [PW-1:0]    w_rdPtrNext;
   logic [CW-1:0]    w_countNext;
   logic             w_headFromIn;

   assign w_push = i_push & (r_count != FULL_LVL);
   assign w_pop  = i_pop & (r_count != '0);

   assign w_wrPtrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PW'(1);
   assign w_rdPtrNext = w_pop ? ((r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PW'(1)) : r_rdPtr;
   assign w_countNext = r_count + CW'(w_push) - CW'(w_pop);

   // The incoming word becomes the head when nothing older survives this edge.
   assign w_headFromIn = w_push & ((r_count == '0) | ((r_count == CW'(1)) & w_pop));

   // Storage carries no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers, occupancy and the registered head word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_head  <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= w_wrPtrNext;
         end
         r_rdPtr <= w_rdPtrNext;
         r_count <= w_countNext;
         if (w_countNext != '0) begin
            r_head <= w_headFromIn ? i_data : r_mem[w_rdPtrNext];
         end
      end
   end

   assign o_data  = r_head;
   assign o_full  = (r_count == FULL_LVL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/demux2way_stream.sv
// Registered 1-to-2 stream demultiplexer with an independent buffer per output.
// Optional delivered-word counters are enabled with DEMUX2WAY_STREAM_COUNT_EN.
module demux2way_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_DEFAULT_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data
`ifdef DEMUX2WAY_STREAM_COUNT_EN
   ,
   output logic [15:0]      a_count,
   output logic [15:0]      b_count
`endif
);

   localparam int CW = clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

   logic [CW-1:0] w_aFill;
   logic [CW-1:0] w_bFill;
   logic          w_aFull;
   logic          w_bFull;
   logic          w_aEmpty;
   logic          w_bEmpty;
   logic          w_accept;
   logic          w_pushA;
   logic          w_pushB;
   logic          w_popA;
   logic          w_popB;

   // Ready looks only at registered occupancy, never at the consumer readies.
   assign in_ready = (in_sel == DEMUX_SEL_B) ? (w_bFill < FULL_LVL) : (w_aFill < FULL_LVL);
   assign w_accept = in_valid & in_ready;
   assign w_pushA  = w_accept & (in_sel == DEMUX_SEL_A) & ~w_aFull;
   assign w_pushB  = w_accept & (in_sel == DEMUX_SEL_B) & ~w_bFull;

   assign a_valid = ~w_aEmpty;
   assign b_valid = ~w_bEmpty;
   assign w_popA  = a_valid & a_ready;
   assign w_popB  = b_valid & b_ready;

   demux_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) fifoA (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_pushA),
      .i_data  (in_data),
      .i_pop   (w_popA),
      .o_data  (a_data),
      .o_full  (w_aFull),
      .o_empty (w_aEmpty),
      .o_count (w_aFill)
   );

   demux_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) fifoB (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_pushB),
      .i_data  (in_data),
      .i_pop   (w_popB),
      .o_data  (b_data),
      .o_full  (w_bFull),
      .o_empty (w_bEmpty),
      .o_count (w_bFill)
   );

`ifdef DEMUX2WAY_STREAM_COUNT_EN
   logic [15:0] r_aCount;
   logic [15:0] r_bCount;

   // Delivered-word counters; they wrap naturally at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_aCount <= '0;
         r_bCount <= '0;
      end else begin
         if (w_popA) begin
            r_aCount <= r_aCount + 16'd1;
         end
         if (w_popB) begin
            r_bCount <= r_bCount + 16'd1;
         end
      end
   end

   assign a_count = r_aCount;
   assign b_count = r_bCount;
`endif

endmodule
